// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous byte FIFO and sends them as UART frames (8N1, LSB first).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after data bit 7 (11-bit frames).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shreg;
    logic          r_tx;
    logic          r_busy;
    logic          w_bit_end;

`ifdef FIFO_UART_TX_PARITY_EN
    logic          r_parity;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    assign w_bit_end = (r_baud_cnt == LAST_CNT);
    assign fifo_read = (r_state == S_IDLE) && !fifo_empty;
    assign tx        = r_tx;
    assign busy      = r_busy;

    // Frame sequencer; tx and busy are loaded from the next-state decode so they move only on bit boundaries
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shreg    <= 8'h00;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (fifo_read) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                // fifo_data was updated by the edge that sampled the read strobe
                S_LOAD: begin
                    r_shreg    <= fifo_data;
                    r_baud_cnt <= '0;
                    r_bit_idx  <= 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
                    r_parity   <= even_parity(fifo_data);
`endif
                    r_state    <= S_START;
                    r_tx       <= 1'b0;
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_DATA;
                        r_tx       <= r_shreg[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_shreg    <= {1'b0, r_shreg[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
                            r_state   <= S_PARITY;
                            r_tx      <= r_parity;
`else
                            r_state   <= S_STOP;
                            r_tx      <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shreg[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_STOP;
                        r_tx       <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_baud_cnt <= '0;
                    r_bit_idx  <= 3'd0;
                    r_tx       <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a small queue standing in for the FIFO.
// Frame patterns below are written first-transmitted-bit-first (start ... stop).
module tb_fifo_uart_tx;

    logic       clk;
    logic       reset_n;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read;
    logic       tx;
    logic       busy;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam int FP = 46;
    localparam logic [10:0] F_A5 = 11'b0_10100101_0_1;
    localparam logic [10:0] F_01 = 11'b0_10000000_1_1;
    localparam logic [10:0] F_FF = 11'b0_11111111_0_1;
    localparam logic [10:0] F_80 = 11'b0_00000001_1_1;
    localparam logic [10:0] F_C3 = 11'b0_11000011_0_1;
    localparam logic [10:0] F_07 = 11'b0_11100000_1_1;
    localparam logic [10:0] F_00 = 11'b0_00000000_0_1;
`else
    localparam int NB = 10;
    localparam int FP = 42;
    localparam logic [10:0] F_A5 = {1'b0, 10'b0_10100101_1};
    localparam logic [10:0] F_01 = {1'b0, 10'b0_10000000_1};
    localparam logic [10:0] F_FF = {1'b0, 10'b0_11111111_1};
    localparam logic [10:0] F_80 = {1'b0, 10'b0_00000001_1};
    localparam logic [10:0] F_C3 = {1'b0, 10'b0_11000011_1};
`endif

    int        n_checks = 0;
    int        n_fail   = 0;
    int        cyc      = 0;
    int        tog_end  = 0;
    int        rd_q[$];
    logic [7:0] fq[$];

    fifo_uart_tx #(.CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .tx         (tx),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: FIFO model pops on the edge that samples read; ends at the next falling edge
    task automatic step();
        logic pend;
        pend = (fifo_read === 1'b1);
        if (pend) rd_q.push_back(cyc);
        @(posedge clk);
        #1;
        if (pend && fq.size() > 0) fifo_data = fq.pop_front();
        cyc++;
        if (cyc < tog_end) fifo_empty = (cyc % 2 == 1);
        else               fifo_empty = (fq.size() == 0);
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
        #1;
    endtask

    // Called in the IDLE cycle where fifo_read should be high; returns in the IDLE cycle after STOP
    task automatic check_frame(input string tag, input logic [10:0] exp_bits);
        logic [10:0] obs;
        logic        stable;
        logic        busy_ok;
        int          rd0;
        rd0 = rd_q.size();
        check({tag, "_read"}, 32'(fifo_read), 32'd1);
        step();
        check({tag, "_load_tx"}, 32'(tx), 32'd1);
        check({tag, "_load_busy"}, 32'(busy), 32'd1);
        step();
        obs = 11'd0;
        stable = 1'b1;
        busy_ok = 1'b1;
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 0) obs[NB-1-k] = tx;
                else if (tx !== obs[NB-1-k]) stable = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
                step();
            end
        end
        check({tag, "_bits"}, 32'(obs), 32'(exp_bits));
        check({tag, "_stable"}, 32'(stable), 32'd1);
        check({tag, "_busy_frame"}, 32'(busy_ok), 32'd1);
        check({tag, "_reads"}, 32'(rd_q.size() - rd0), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_tx"}, 32'(tx), 32'd1);
    endtask

    initial begin
        int txl;
        int bz;
        int rd0;
        reset_n    = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_read", 32'(fifo_read), 32'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);

        // Empty FIFO for 200 cycles
        txl = 0; bz = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx !== 1'b1) txl++;
            if (busy !== 1'b0) bz++;
            step();
        end
        check("idle_tx_low", 32'(txl), 32'd0);
        check("idle_busy", 32'(bz), 32'd0);
        check("idle_reads", 32'(rd_q.size()), 32'd0);

        // Single byte
        push(8'hA5);
        check_frame("a5", F_A5);
        repeat (5) step();
        check("a5_no_more_reads", 32'(rd_q.size()), 32'd1);

        // Back-to-back bytes
        rd0 = rd_q.size();
        push(8'h01); push(8'hFF); push(8'h80);
        check_frame("b01", F_01);
        check_frame("bff", F_FF);
        check_frame("b80", F_80);
        repeat (10) step();
        check("b2b_reads", 32'(rd_q.size() - rd0), 32'd3);
        check("b2b_period0", 32'(rd_q[rd0+1] - rd_q[rd0]), 32'(FP));
        check("b2b_period1", 32'(rd_q[rd0+2] - rd_q[rd0+1]), 32'(FP));

`ifdef FIFO_UART_TX_PARITY_EN
        push(8'h07); push(8'h00);
        check_frame("p07", F_07);
        check_frame("p00", F_00);
        repeat (5) step();
`endif

        // Reset in the middle of data bit 3 of 0x3C
        push(8'h3C);
        check("r3c_read", 32'(fifo_read), 32'd1);
        step(); step();
        check("r3c_start", 32'(tx), 32'd0);
        repeat (14) step();
        check("r3c_bit2", 32'(tx), 32'd1);
        step(); step();
        check("r3c_busy_pre", 32'(busy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("r3c_tx_async", 32'(tx), 32'd1);
        check("r3c_busy_async", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        rd0 = rd_q.size();
        txl = 0; bz = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1) txl++;
            if (busy !== 1'b0) bz++;
            step();
        end
        check("r3c_after_tx", 32'(txl), 32'd0);
        check("r3c_after_busy", 32'(bz), 32'd0);
        check("r3c_after_reads", 32'(rd_q.size() - rd0), 32'd0);

        // Reset during the start bit forces the line high
        push(8'h3C);
        step(); step(); step();
        check("rst_start_pre", 32'(tx), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("rst_start_tx", 32'(tx), 32'd1);
        check("rst_start_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);

        // fifo_empty toggling every cycle during a frame
        rd0 = rd_q.size();
        tog_end = cyc + 2 + NB * 4;
        push(8'hC3);
        check_frame("tog", F_C3);
        repeat (10) step();
        check("tog_reads", 32'(rd_q.size() - rd0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
